// File: rtl/spi_slave_pkg.sv
// Shared register map and reset values for the SPI slave configuration register file.
package spi_slave_pkg;

    localparam int unsigned REG_MODE     = 0;
    localparam int unsigned REG_DUMMY    = 1;
    localparam int unsigned REG_WRAP_LO  = 2;
    localparam int unsigned REG_WRAP_HI  = 3;
    localparam int unsigned REG_STATUS   = 4;
    localparam int unsigned SCRATCH_BASE = 5;

    localparam int unsigned MODE_RST          = 0;
    localparam int unsigned DUMMY_RST_DEFAULT = 32;
    localparam int unsigned WRAP_RST          = 0;
    localparam int unsigned HOLD_RST          = 0;
    localparam int unsigned STATUS_RST        = 0;
    localparam int unsigned SCRATCH_RST       = 0;

endpackage

// File: rtl/spi_slave_addr_ptr.sv
// Auto-incrementing access pointer: an optional load selects this cycle's address,
// and any access advances the pointer by one past it, wrapping modulo 2**ADDR_W.
module spi_slave_addr_ptr #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cur;

    always_comb begin
        cur   = load_i ? load_addr_i : ptr_q;
        ptr_d = step_i ? cur + ADDR_W'(1) : cur;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign addr_o = cur;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave configuration register file: mode, dummy cycles, atomically committed
// wrap length, W1C sticky status and scratch registers behind an auto-increment pointer.
module spi_slave_regfile
    import spi_slave_pkg::*;
#(
    parameter int unsigned REG_SIZE  = 8,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned DUMMY_RST = DUMMY_RST_DEFAULT,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  addr_load,
    input  logic [ADDR_W-1:0]     addr_in,
    input  logic [REG_SIZE-1:0]   wr_data,
    input  logic                  wr_data_valid,
    input  logic                  rd_req,
    output logic [REG_SIZE-1:0]   rd_data,
    output logic                  rd_valid,
    input  logic [REG_SIZE-1:0]   status_set,
    output logic                  quad_en,
    output logic [REG_SIZE-1:0]   dummy_cycles,
    output logic [2*REG_SIZE-1:0] wrap_length,
    output logic                  cfg_update
);

    logic [ADDR_W-1:0]     acc_addr;
    logic [REG_SIZE-1:0]   mode_q, mode_d;
    logic [REG_SIZE-1:0]   dummy_q, dummy_d;
    logic [REG_SIZE-1:0]   shadow_q, shadow_d;
    logic [2*REG_SIZE-1:0] wrap_q, wrap_d;
    logic [REG_SIZE-1:0]   hold_q, hold_d;
    logic                  hold_pend_q, hold_pend_d;
    logic [REG_SIZE-1:0]   status_q, status_d;
    logic [REG_SIZE-1:0]   scratch_q [NUM_REGS];
    logic [REG_SIZE-1:0]   scratch_d [NUM_REGS];
    logic [REG_SIZE-1:0]   rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  cfg_upd_q, cfg_upd_d;
    logic [REG_SIZE-1:0]   rd_val;
    logic [REG_SIZE-1:0]   status_clr;

    spi_slave_addr_ptr #(
        .ADDR_W (ADDR_W)
    ) u_ptr (
        .clk_i       (sclk),
        .rst_i       (rst),
        .load_i      (addr_load),
        .load_addr_i (addr_in),
        .step_i      (wr_data_valid | rd_req),
        .addr_o      (acc_addr)
    );

    // Reads see pre-write values; reg3 returns the snapshot taken by the last reg2 read once.
    always_comb begin
        case (acc_addr)
            ADDR_W'(REG_MODE):    rd_val = mode_q;
            ADDR_W'(REG_DUMMY):   rd_val = dummy_q;
            ADDR_W'(REG_WRAP_LO): rd_val = shadow_q;
            ADDR_W'(REG_WRAP_HI): rd_val = hold_pend_q ? hold_q : wrap_q[2*REG_SIZE-1:REG_SIZE];
            ADDR_W'(REG_STATUS):  rd_val = status_q;
            default:              rd_val = scratch_q[acc_addr];
        endcase
    end

    always_comb begin
        mode_d      = mode_q;
        dummy_d     = dummy_q;
        shadow_d    = shadow_q;
        wrap_d      = wrap_q;
        hold_d      = hold_q;
        hold_pend_d = hold_pend_q;
        scratch_d   = scratch_q;
        cfg_upd_d   = 1'b0;
        status_clr  = '0;

        if (wr_data_valid) begin
            case (acc_addr)
                ADDR_W'(REG_MODE):    begin mode_d  = wr_data; cfg_upd_d = 1'b1; end
                ADDR_W'(REG_DUMMY):   begin dummy_d = wr_data; cfg_upd_d = 1'b1; end
                ADDR_W'(REG_WRAP_LO): shadow_d = wr_data;
                ADDR_W'(REG_WRAP_HI): begin wrap_d = {wr_data, shadow_q}; cfg_upd_d = 1'b1; end
                ADDR_W'(REG_STATUS):  status_clr = wr_data;
                default:              scratch_d[acc_addr] = wr_data;
            endcase
        end

        if (rd_req && acc_addr == ADDR_W'(REG_WRAP_LO)) begin
            hold_d      = wrap_q[2*REG_SIZE-1:REG_SIZE];
            hold_pend_d = 1'b1;
        end else if (rd_req && acc_addr == ADDR_W'(REG_WRAP_HI)) begin
            hold_pend_d = 1'b0;
        end

        status_d   = (status_q & ~status_clr) | status_set;
        rd_valid_d = rd_req;
        rd_data_d  = rd_req ? rd_val : rd_data_q;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            mode_q      <= REG_SIZE'(MODE_RST);
            dummy_q     <= REG_SIZE'(DUMMY_RST);
            shadow_q    <= REG_SIZE'(WRAP_RST);
            wrap_q      <= (2*REG_SIZE)'(WRAP_RST);
            hold_q      <= REG_SIZE'(HOLD_RST);
            hold_pend_q <= 1'b0;
            status_q    <= REG_SIZE'(STATUS_RST);
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                scratch_q[i] <= REG_SIZE'(SCRATCH_RST);
            end
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            cfg_upd_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            dummy_q     <= dummy_d;
            shadow_q    <= shadow_d;
            wrap_q      <= wrap_d;
            hold_q      <= hold_d;
            hold_pend_q <= hold_pend_d;
            status_q    <= status_d;
            scratch_q   <= scratch_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            cfg_upd_q   <= cfg_upd_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign quad_en      = mode_q[0];
    assign dummy_cycles = dummy_q;
    assign wrap_length  = wrap_q;
    assign cfg_update   = cfg_upd_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed scoreboard bench for spi_slave_regfile: reads push expected data into a queue,
// a negedge monitor pops and compares on rd_valid and counts cfg_update pulses.
module tb_spi_slave_regfile;

    logic        sclk = 1'b0;
    logic        rst;
    logic        addr_load;
    logic [2:0]  addr_in;
    logic [7:0]  wr_data;
    logic        wr_data_valid;
    logic        rd_req;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  status_set;
    logic        quad_en;
    logic [7:0]  dummy_cycles;
    logic [15:0] wrap_length;
    logic        cfg_update;

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned cfg_cnt = 0;

    always #5 sclk = ~sclk;

    spi_slave_regfile #(
        .REG_SIZE  (8),
        .NUM_REGS  (8),
        .DUMMY_RST (32)
    ) dut (
        .sclk          (sclk),
        .rst           (rst),
        .addr_load     (addr_load),
        .addr_in       (addr_in),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .rd_req        (rd_req),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .status_set    (status_set),
        .quad_en       (quad_en),
        .dummy_cycles  (dummy_cycles),
        .wrap_length   (wrap_length),
        .cfg_update    (cfg_update)
    );

    always @(posedge sclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge sclk) begin
        if (cfg_update === 1'b1) cfg_cnt++;
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got rd_valid with data 0x%0h, expected no read (t=%0t)", rd_data, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic op(input logic ld, input logic [2:0] a, input logic wr, input logic [7:0] d,
                      input logic rd, input logic [7:0] exp);
        addr_load     = ld;
        addr_in       = a;
        wr_data_valid = wr;
        wr_data       = d;
        rd_req        = rd;
        if (rd) sb.push_back('{data: exp, cyc: cyc + 1});
        tick();
        addr_load     = 1'b0;
        addr_in       = '0;
        wr_data_valid = 1'b0;
        wr_data       = '0;
        rd_req        = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; addr_load = 1'b0; addr_in = '0; wr_data = '0;
        wr_data_valid = 1'b0; rd_req = 1'b0; status_set = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_cfg_update", cfg_update, 0);
        check("rst_quad_en", quad_en, 0);
        check("rst_dummy", dummy_cycles, 32);
        check("rst_wrap", wrap_length, 0);

        op(1, 1, 0, 8'h00, 1, 8'd32);
        tick();

        op(1, 5, 1, 8'h5A, 0, 8'h00);

        op(1, 2, 1, 8'h34, 0, 8'h00);
        check("wrap_after_lo", wrap_length, 16'h0000);
        op(0, 0, 1, 8'h12, 0, 8'h00);
        check("wrap_commit", wrap_length, 16'h1234);
        tick();
        check("cfg_cnt_wrap", cfg_cnt, 1);
        op(0, 0, 0, 8'h00, 1, 8'h00);
        op(0, 0, 0, 8'h00, 1, 8'h5A);

        op(1, 7, 1, 8'hAA, 0, 8'h00);
        op(0, 0, 1, 8'hBB, 0, 8'h00);
        check("quad_en_set", quad_en, 1);
        tick();
        check("cfg_cnt_mode", cfg_cnt, 2);
        op(1, 7, 0, 8'h00, 1, 8'hAA);
        op(0, 0, 0, 8'h00, 1, 8'hBB);

        op(1, 5, 1, 8'h77, 1, 8'h5A);
        op(0, 0, 0, 8'h00, 1, 8'h00);
        op(1, 5, 0, 8'h00, 1, 8'h77);

        status_set = 8'h05;
        tick();
        status_set = 8'h01;
        op(1, 4, 1, 8'h07, 0, 8'h00);
        status_set = 8'h00;
        op(1, 4, 0, 8'h00, 1, 8'h01);
        tick();
        check("cfg_cnt_status", cfg_cnt, 2);

        op(1, 2, 0, 8'h00, 1, 8'h34);
        op(1, 3, 1, 8'h56, 0, 8'h00);
        check("wrap_recommit", wrap_length, 16'h5634);
        op(1, 3, 0, 8'h00, 1, 8'h12);
        tick();
        check("cfg_cnt_wrap2", cfg_cnt, 3);

        op(1, 1, 1, 8'h10, 0, 8'h00);
        check("dummy_write", dummy_cycles, 8'h10);
        rst = 1'b1; addr_load = 1'b1; addr_in = 3'd1; wr_data_valid = 1'b1; wr_data = 8'h99;
        tick();
        rst = 1'b0; addr_load = 1'b0; addr_in = '0; wr_data_valid = 1'b0; wr_data = '0;
        check("rst_prio_dummy", dummy_cycles, 32);
        check("rst_prio_cfg", cfg_update, 0);
        check("rst_prio_wrap", wrap_length, 0);
        check("rst_prio_quad", quad_en, 0);
        check("rst_prio_rd_data", rd_data, 0);
        op(0, 0, 0, 8'h00, 1, 8'h00);
        op(0, 0, 0, 8'h00, 1, 8'd32);
        op(1, 2, 0, 8'h00, 1, 8'h00);
        tick();
        check("cfg_cnt_final", cfg_cnt, 4);

        tick();
        tick();
        check("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_regfile.md
SPI_SLAVE_REGFILE -- requirements
Module: spi_slave_regfile

Interface
REQ-001 SHALL have parameter REG_SIZE, default 8, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, register count (power of two, >=8); localparam ADDR_W = log2(NUM_REGS).
REQ-003 SHALL have parameter DUMMY_RST, default 32, reset value of the dummy-cycle register.
REQ-004 SHALL have ports:
- sclk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- addr_load  in  1  load the access pointer from addr_in
- addr_in  in  ADDR_W  start address
- wr_data  in  REG_SIZE  write data
- wr_data_valid  in  1  write strobe at the pointer
- rd_req  in  1  read strobe at the pointer
- rd_data  out  REG_SIZE  registered read data
- rd_valid  out  1  rd_data valid pulse
- status_set  in  REG_SIZE  hardware sticky-status set bits
- quad_en  out  1  reg0 bit 0
- dummy_cycles  out  REG_SIZE  reg1
- wrap_length  out  2*REG_SIZE  committed {reg3, reg2}
- cfg_update  out  1  one-cycle pulse on configuration change

Function
REQ-005 SHALL map registers: 0 mode, 1 dummy cycles, 2 wrap low, 3 wrap high, 4 status (W1C), 5..NUM_REGS-1 scratch.
REQ-006 SHALL keep an ADDR_W-bit access pointer; on addr_load the access in that cycle uses addr_in and the pointer becomes addr_in+1 if an access occurs, else addr_in.
REQ-007 SHALL increment the pointer by exactly one, mod NUM_REGS (NUM_REGS-1 wraps to 0), for any cycle with wr_data_valid or rd_req, including both together.
REQ-008 SHALL, on wr_data_valid, update the target register at the next edge; regs 0, 1 and scratch take wr_data directly.
REQ-009 SHALL write reg2 into a shadow only; a write to reg3 SHALL commit {wr_data, shadow} to wrap_length atomically in one edge.
REQ-010 SHALL read reg2 as the shadow value, and SHALL snapshot committed reg3 into a hold register when reg2 is read; the next read of reg3 SHALL return the hold value.
REQ-011 SHALL clear status bits written as 1 and leave bits written as 0; status_set bits SHALL set their bit every cycle, and set SHALL win over a same-cycle clear.
REQ-012 SHALL return on rd_req the register value at the pointer before any same-cycle write, on rd_data with rd_valid high exactly one cycle later (latency 1); rd_data SHALL hold between reads.
REQ-013 SHALL pulse cfg_update for one cycle, the cycle after a write to reg0, reg1 or reg3; writes to reg2, status or scratch SHALL NOT pulse it.
REQ-014 SHALL drive quad_en, dummy_cycles and wrap_length from registers only; they SHALL never show a half-committed wrap value.

Reset
REQ-015 SHALL, on rst high at a rising edge, set: pointer 0; reg0 0; reg1 DUMMY_RST; shadow, committed wrap, hold, status and scratch 0; rd_data 0; rd_valid 0; cfg_update 0.
REQ-016 SHALL give rst priority over every strobe in the same cycle; a pending shadow write is discarded.

Structure
REQ-017 SHALL place register index constants (REG_MODE, REG_DUMMY, REG_WRAP_LO, REG_WRAP_HI, REG_STATUS) and the reset value of each register in shared package spi_slave_pkg.
REQ-018 SHALL implement the access pointer (load, increment, wrap) as sub-module spi_slave_addr_ptr.

Verification
REQ-019 Reset, then read reg1 -> rd_data=32 one cycle after rd_req; wrap_length=0; quad_en=0.
REQ-020 addr_load addr_in=2, write 0x34 then 0x12 -> wrap_length stays 0 after the first write and becomes 0x1234 after the second; one cfg_update pulse; pointer=4.
REQ-021 addr_load addr_in=7 (NUM_REGS=8), write 0xAA, 0xBB -> reg7=0xAA, reg0=0xBB, quad_en=1, cfg_update pulses.
REQ-022 status_set=0x05 for one cycle, then write 0x07 to reg4 while status_set=0x01 -> status=0x01.
REQ-023 With wrap committed 0x1234: read reg2, hardware-free write of reg3=0x56 via a reloaded pointer, then read reg3 -> returns 0x12 (hold), wrap_length=0x5634.
REQ-024 Write reg1=0x10, assert rst in the next cycle together with wr_data_valid -> reg1=32, cfg_update=0, pointer=0.
